// File: rtl/rv32i_instr_encoder_if.sv
// Request/write-port bundle between a program loader and the RV32I instruction encoder.
// master drives field requests and program control; slave returns handshake, imem writes and status.
interface rv32i_instr_encoder_if #(
   parameter int ADDR_W = 6
);
   logic              start;
   logic              finish;
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        kind;
   logic [4:0]        rd;
   logic [4:0]        rs1;
   logic [4:0]        rs2;
   logic [2:0]        func3;
   logic              func7_5;
   logic [31:0]       imm;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic [ADDR_W:0]   count;
   logic              err;
   logic              done;

   modport master (
      output start, finish, in_valid, kind, rd, rs1, rs2, func3, func7_5, imm,
      input  in_ready, imem_we, imem_addr, imem_wdata, count, err, done
   );

   modport slave (
      input  start, finish, in_valid, kind, rd, rs1, rs2, func3, func7_5, imm,
      output in_ready, imem_we, imem_addr, imem_wdata, count, err, done
   );
endinterface

// File: rtl/rv32i_instr_encoder.sv
// Encodes load / R-type / branch / I-ALU field requests into RV32I words and writes them
// sequentially into instruction memory; illegal immediates are rejected with a sticky error.
module rv32i_instr_encoder #(
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   rv32i_instr_encoder_if.slave bus
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_IALU = 7'b0010011;

   state_t            state_r, state_n;
   logic [ADDR_W-1:0] ptr_r;
   logic [ADDR_W:0]   count_r;
   logic              err_r;
   logic              we_r;
   logic              done_r;
   logic [ADDR_W-1:0] addr_r;
   logic [31:0]       wdata_r;

   logic              ready_s;
   logic              accept_s;
   logic              shift_s;
   logic              last_s;
   logic              legal_s;
   logic [31:0]       enc_s;
   logic signed [31:0] simm_s;

   // finish wins over a concurrent request, so it is folded into ready
   assign ready_s  = (state_r == ST_RUN) && (count_r < DEPTH_C) && !bus.finish;
   assign accept_s = bus.in_valid && ready_s;
   assign simm_s   = $signed(bus.imm);
   assign shift_s  = (bus.func3[1:0] == 2'b01);
   assign last_s   = ((count_r + (ADDR_W + 1)'(1'b1)) == DEPTH_C);

   // Instruction word assembly and immediate legality per opcode class
   always_comb begin
      enc_s   = 32'h0000_0000;
      legal_s = 1'b0;
      case (bus.kind)
         2'b00: begin
            enc_s   = {bus.imm[11:0], bus.rs1, bus.func3, bus.rd, OP_LOAD};
            legal_s = (simm_s >= -32'sd2048) && (simm_s <= 32'sd2047);
         end
         2'b01: begin
            enc_s   = {1'b0, bus.func7_5, 5'b00000, bus.rs2, bus.rs1, bus.func3, bus.rd, OP_R};
            legal_s = 1'b1;
         end
         2'b10: begin
            enc_s   = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.func3,
                       bus.imm[4:1], bus.imm[11], OP_BR};
            legal_s = (simm_s >= -32'sd4096) && (simm_s <= 32'sd4094) && !bus.imm[0];
         end
         2'b11: begin
            if (shift_s) begin
               enc_s   = {1'b0, bus.func7_5, 5'b00000, bus.imm[4:0], bus.rs1, bus.func3,
                          bus.rd, OP_IALU};
               // SLLI has no arithmetic variant, so bit 30 must stay clear
               legal_s = (bus.imm[31:5] == 27'd0) && !(!bus.func3[2] && bus.func7_5);
            end else begin
               enc_s   = {bus.imm[11:0], bus.rs1, bus.func3, bus.rd, OP_IALU};
               legal_s = (simm_s >= -32'sd2048) && (simm_s <= 32'sd2047);
            end
         end
         default: begin
            enc_s   = 32'h0000_0000;
            legal_s = 1'b0;
         end
      endcase
   end

   // Program state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_n;
      end
   end

   // Next-state logic; start is ignored while a program is running
   always_comb begin
      state_n = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) state_n = ST_RUN;
            else           state_n = ST_IDLE;
         end
         ST_RUN: begin
            if (bus.finish || (accept_s && legal_s && last_s)) state_n = ST_DONE;
            else                                               state_n = ST_RUN;
         end
         ST_DONE: begin
            if (bus.start) state_n = ST_RUN;
            else           state_n = ST_DONE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Write port, pointer/count and sticky error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r   <= '0;
         count_r <= '0;
         err_r   <= 1'b0;
         we_r    <= 1'b0;
         done_r  <= 1'b0;
         addr_r  <= '0;
         wdata_r <= 32'h0000_0000;
      end else begin
         we_r   <= 1'b0;
         done_r <= (state_n == ST_DONE);
         if ((state_r != ST_RUN) && (state_n == ST_RUN)) begin
            ptr_r   <= '0;
            count_r <= '0;
            err_r   <= 1'b0;
         end else if (accept_s) begin
            if (legal_s) begin
               we_r    <= 1'b1;
               addr_r  <= ptr_r;
               wdata_r <= enc_s;
               ptr_r   <= ptr_r + ADDR_W'(1'b1);
               count_r <= count_r + (ADDR_W + 1)'(1'b1);
            end else begin
               err_r <= 1'b1;
            end
         end
      end
   end

   assign bus.in_ready   = ready_s;
   assign bus.imem_we    = we_r;
   assign bus.imem_addr  = addr_r;
   assign bus.imem_wdata = wdata_r;
   assign bus.count      = count_r;
   assign bus.err        = err_r;
   assign bus.done       = done_r;
endmodule

// File: doc/rv32i_instr_encoder.md
Name: rv32i_instr_encoder

Overview:
- Encoder counterpart to the control decoder. Converts field-level instruction requests into 32-bit RV32I words and writes them sequentially into instruction memory.
- Covers the four opcode classes the datapath decodes: load, R-type, branch, I-type ALU.
- Sits between the test/boot loader and the instruction memory write port. Used to build programs in simulation and at boot.

Parameters:
- ADDR_W, 6, width of the imem word address.
- DEPTH, 64, number of words the encoder may write (2 ≤ DEPTH ≤ 2^ADDR_W).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a new program at word 0; clears err and count.
- finish  input  1  close the current program.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted this cycle when in_valid && in_ready.
- kind  input  2  00 load, 01 R-type, 10 branch, 11 I-type ALU.
- rd  input  5  destination register.
- rs1  input  5  source register 1.
- rs2  input  5  source register 2.
- func3  input  3  funct3 field.
- func7_5  input  1  instruction bit 30 (SUB/SRA/SRAI).
- imm  input  32  signed immediate, byte offset for branches.
- imem_we  output  1  write strobe, one cycle per word.
- imem_addr  output  ADDR_W  word address.
- imem_wdata  output  32  encoded instruction.
- count  output  ADDR_W+1  number of words written in the current program.
- err  output  1  sticky: a request was rejected.
- done  output  1  high in the DONE state.

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready, imem_we, imem_addr, imem_wdata, count, err and done all 0. A reset mid-RUN discards any pending write.
- States: IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - RUN --finish, or count reaches DEPTH--> DONE.
  - DONE --start--> RUN.
  - start in RUN is ignored.
  - Entering RUN clears the write pointer, count and err.
- in_ready = (state==RUN) && (count < DEPTH) && !finish.
- Encoding, with opcode per kind:
  - Load (0000011): {imm[11:0], rs1, func3, rd, op}.
  - R-type (0110011): {1'b0, func7_5, 5'b0, rs2, rs1, func3, rd, op}.
  - Branch (1100011): {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], op}.
  - I-ALU (0010011): {imm[11:0], rs1, func3, rd, op}. For func3 001/101 (shifts), bits [31:25] = {1'b0, func7_5, 5'b0} and bits [24:20] = imm[4:0].
- Legality checks:
  - Load and I-ALU non-shift: imm in [-2048, 2047].
  - Branch: imm in [-4096, 4094] and even.
  - Shift: imm in [0, 31]; func3 001 additionally requires func7_5=0.
- Accepted legal request: imem_we=1 exactly on the next cycle (latency 1), with imem_addr = current pointer and imem_wdata = encoded word. Pointer and count increment on the same edge.
- Accepted illegal request: no write; err set (sticky until the next entry to RUN); pointer unchanged.
- imem_we=0 on every cycle without a registered legal accept. imem_addr and imem_wdata hold their last values.
- Simultaneous finish and in_valid: no accept (in_ready=0); transition to DONE.
- When count reaches DEPTH after a write, the state goes to DONE on that same edge. in_ready is already low that cycle because of the count check.
- done=1 only in DONE; in_ready=0 in IDLE and DONE.

Test Plan:
- start, then add x3,x1,x2 (kind=01, rd=3, rs1=1, rs2=2, f3=0, f7_5=0) -> next cycle imem_we=1, addr=0, wdata=0x002081B3; count=1.
- lw x5,-4(x2) (kind=00, rd=5, rs1=2, f3=010, imm=-4) -> wdata=0xFFC12283 at addr=1.
- beq x1,x2,-8 (kind=10, rs1=1, rs2=2, f3=000, imm=-8) -> wdata=0xFE208CE3. srai x4,x4,3 (kind=11, f3=101, f7_5=1, imm=3) -> wdata=0x40325213.
- Branch imm=5, then addi imm=2048 -> no imem_we, err=1, count unchanged. Next legal request writes to the unchanged address. A subsequent start clears err to 0.
- DEPTH=4: four back-to-back legal accepts -> addrs 0..3 on consecutive cycles, done=1 after the 4th, in_ready=0. A held 5th request is not accepted.
- rst_n low mid-RUN with an accept in flight -> all outputs 0 immediately; no write on the following cycle; state IDLE.
